// File: rtl/ifetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular FIFO of {instr, pc} with redirect flush.
// Define IFETCH_QUEUE_BYPASS_EN to forward enq_* straight to deq_* while the queue is empty.
module ifetch_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [INSTR_WIDTH-1:0]       enq_instr,
    input  logic [ADDR_WIDTH-1:0]        enq_pc,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [INSTR_WIDTH-1:0]       deq_instr,
    output logic [ADDR_WIDTH-1:0]        deq_pc,
    input  logic                         flush,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         almost_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr, wr_ptr_n;
    logic [PW-1:0]   rd_ptr, rd_ptr_n;
    logic [CW-1:0]   count_q, count_n;
    logic            dv_q, dv_n;
    logic            er_q, er_n;
    logic            af_q, af_n;
    entry_t          head_q, head_n;
    entry_t          enq_entry;
    logic            wr_en;
    logic            rd_en;
    logic            byp;

    assign enq_entry = '{instr: enq_instr, pc: enq_pc};

`ifdef IFETCH_QUEUE_BYPASS_EN
    // Empty queue forwards the incoming instruction in the same cycle unless redirected.
    assign byp       = (count_q == '0) && enq_valid && !flush;
    assign deq_valid = dv_q | byp;
    assign deq_instr = byp ? enq_instr : head_q.instr;
    assign deq_pc    = byp ? enq_pc    : head_q.pc;
`else
    assign byp       = 1'b0;
    assign deq_valid = dv_q;
    assign deq_instr = head_q.instr;
    assign deq_pc    = head_q.pc;
`endif

    assign enq_ready   = er_q;
    assign almost_full = af_q;
    assign count       = count_q;

    // Next-state: pointers, occupancy, status flags and the pre-fetched head entry.
    always_comb begin
        wr_en    = enq_valid && er_q && !(byp && deq_ready);
        rd_en    = dv_q && deq_ready;
        wr_ptr_n = wr_ptr + PW'(wr_en);
        rd_ptr_n = rd_ptr + PW'(rd_en);
        count_n  = count_q + CW'(wr_en) - CW'(rd_en);
        if (flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
        end
        head_n = '0;
        if (count_n != '0) begin
            // The entry being written becomes head when the queue would otherwise be empty.
            head_n = (wr_en && (wr_ptr == rd_ptr_n)) ? enq_entry : mem[rd_ptr_n];
        end
        dv_n = (count_n != '0);
        er_n = (count_n != CW'(DEPTH));
        af_n = (count_n >= CW'(DEPTH - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            dv_q    <= 1'b0;
            er_q    <= 1'b1;
            af_q    <= 1'b0;
            head_q  <= '0;
        end else begin
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            count_q <= count_n;
            dv_q    <= dv_n;
            er_q    <= er_n;
            af_q    <= af_n;
            head_q  <= head_n;
        end
    end

    // Entry storage carries no reset; unread slots never reach the outputs.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr] <= enq_entry;
        end
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Decoupling instruction buffer between the instruction fetch unit and the instruction execution unit inside the single-threaded pipeline.
- Absorbs fetch bursts while execution stalls on lane back-pressure.
- Presents instructions in program order with their PC.
- Supports a redirect flush that discards all buffered, now-wrong-path instructions.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- INSTR_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous active-low reset (0 = in reset).
- enq_valid  input  1  fetch unit presents an instruction.
- enq_ready  output  1  queue can accept an instruction this cycle.
- enq_instr  input  INSTR_WIDTH  fetched instruction word.
- enq_pc  input  ADDR_WIDTH  PC of the fetched instruction.
- deq_valid  output  1  head entry valid toward execution.
- deq_ready  input  1  execution unit consumes the head this cycle.
- deq_instr  output  INSTR_WIDTH  head instruction word.
- deq_pc  output  ADDR_WIDTH  head PC.
- flush  input  1  redirect; discard all entries.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= DEPTH-1; fetch uses it to throttle requests.

Behaviour:
- Storage: circular buffer of DEPTH entries, each {instr, pc}.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is held in a separate register.
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - deq_valid=0, enq_ready=1, almost_full=0.
  - deq_instr=0, deq_pc=0; entry storage need not be cleared.
- Enqueue fires when enq_valid && enq_ready at a rising edge: entry[wr_ptr] is written, wr_ptr+1.
- Dequeue fires when deq_valid && deq_ready at a rising edge: rd_ptr+1.
- count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged when both fire.
- enq_ready = (count != DEPTH).
  - Registered-state function only; no combinational path from deq_ready.
  - When full, an enqueue is refused even if a dequeue fires in the same cycle.
- deq_valid = (count != 0).
  - deq_instr/deq_pc = entry[rd_ptr]; they are zero when count=0.
- Latency: an instruction enqueued at edge N is visible on deq_* after edge N (next cycle). Minimum latency is 1 cycle, excluding the optional feature.
- Ordering: strict FIFO; PCs leave in the order they entered.
- Empty: a dequeue is impossible (deq_valid=0), and deq_ready is ignored.
- Full: enq_ready=0, and enq_valid is ignored with no overwrite.
- Flush (synchronous, sampled at the edge):
  - Next state is wr_ptr=rd_ptr=0, count=0.
  - Flush has priority over an enqueue in the same cycle; the enqueued instruction is dropped.
  - A dequeue handshake in the flush cycle is still considered consumed by execution; the queue state is simply cleared.
  - enq_ready is 1 the cycle after flush.
- Reset asserted mid-operation: all contents are lost immediately; outputs take reset values asynchronously.
- No X may propagate onto deq_instr/deq_pc while deq_valid=0.

Optional Feature:
- Macro: IFETCH_QUEUE_BYPASS_EN.
- With the macro defined:
  - When count=0 and enq_valid=1, the input is forwarded combinationally: deq_valid=1, deq_instr=enq_instr, deq_pc=enq_pc.
  - If deq_ready=1 in that cycle, nothing is written and count stays 0 (zero-latency path).
  - If deq_ready=0, the entry is written normally.
  - Flush suppresses the bypass: deq_valid=0 in a flush cycle with count=0.
- Without the macro: no combinational path from enq_* to deq_*; minimum latency is 1 cycle.

Test Plan:
1. Reset with reset=0, then release; no traffic -> count=0, deq_valid=0, enq_ready=1, almost_full=0, deq_pc=0.
2. Enqueue PCs 0x100,0x104,0x108,0x10C on consecutive cycles with deq_ready=0, DEPTH=4 -> count 1,2,3,4; almost_full=1 from count=3; enq_ready=0 at count=4; a fifth enq_valid with pc=0x110 is refused.
3. From full, drive deq_ready=1 and enq_valid=1 (pc=0x110) -> the first cycle only dequeues (0x100, count=3); the next cycle both fire and count stays 3. The output order is 0x104,0x108,0x10C,0x110, exercising pointer wrap.
4. Fill 3 entries, then assert flush with enq_valid=1 (pc=0x200) -> next cycle count=0, deq_valid=0, enq_ready=1; 0x200 never appears on deq_pc.
5. Drive continuous enq/deq streaming for 2*DEPTH+3 instructions, PCs incrementing by 4 -> steady state count=1 (count=0 with bypass), no drops, PCs in order, wrap exercised twice.
6. Bypass build with empty queue, enq_valid=1, pc=0x300, deq_ready=1 -> same-cycle deq_valid=1, deq_pc=0x300, count stays 0. Non-bypass build, same stimulus -> deq_pc=0x300 appears one cycle later.
